// File: rtl/mips_control_multicycle_wdt_if.sv
// Control-unit bus: opcode/handshake from the datapath, control strobes back to it.
// master = datapath side, slave = the control unit.
interface mips_control_multicycle_wdt_if #(
  parameter int WDT_W = 16
);
  logic [5:0]       i_op_code;
  logic             i_mem_ready;
  logic [WDT_W-1:0] i_wdt_period;

  logic       o_ir_en;
  logic       o_pc_en;
  logic       o_is_jump;
  logic       o_is_branch;
  logic       o_r_1_en;
  logic       o_r_2_en;
  logic       o_w_en;
  logic       o_reg_dst;
  logic       o_alu_src;
  logic       o_mem_to_reg;
  logic       o_mem_read;
  logic       o_mem_write;
  logic [1:0] o_alu_op_code;
  logic       o_wdt_wait_period_w_en;
  logic [2:0] o_state;
  logic       o_retire;
  logic       o_illegal;
  logic       o_wdt_timeout;

  modport master (
    output i_op_code, i_mem_ready, i_wdt_period,
    input  o_ir_en, o_pc_en, o_is_jump, o_is_branch, o_r_1_en, o_r_2_en, o_w_en,
           o_reg_dst, o_alu_src, o_mem_to_reg, o_mem_read, o_mem_write, o_alu_op_code,
           o_wdt_wait_period_w_en, o_state, o_retire, o_illegal, o_wdt_timeout
  );

  modport slave (
    input  i_op_code, i_mem_ready, i_wdt_period,
    output o_ir_en, o_pc_en, o_is_jump, o_is_branch, o_r_1_en, o_r_2_en, o_w_en,
           o_reg_dst, o_alu_src, o_mem_to_reg, o_mem_read, o_mem_write, o_alu_op_code,
           o_wdt_wait_period_w_en, o_state, o_retire, o_illegal, o_wdt_timeout
  );
endinterface

// File: rtl/mips_control_multicycle_wdt.sv
// Multicycle MIPS control FSM (fetch/decode/execute/mem/writeback) with a
// programmable watchdog that forces a refetch when no instruction retires in time.
module mips_control_multicycle_wdt #(
  parameter int             WDT_W       = 16,
  parameter logic [WDT_W-1:0] WDT_DEFAULT = {WDT_W{1'b1}},
  parameter logic [5:0]     OP_WDT      = 6'h3F
) (
  input logic                      i_clk,
  input logic                      i_reset,
  mips_control_multicycle_wdt_if.slave bus
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4
  } state_t;

  typedef struct packed {
    logic       ir_en;
    logic       is_jump;
    logic       is_branch;
    logic       r_1_en;
    logic       r_2_en;
    logic       w_en;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
    logic       wdt_w_en;
    logic       retire;          // unconditional retire of this state
    logic       retire_on_ready; // sw in MEM retires in the cycle memory completes
    logic       illegal;
  } ctl_t;

  state_t           state_q, nxt_state;
  logic [5:0]       op_q, nxt_op;
  ctl_t             ctl_q;
  logic [WDT_W-1:0] period_q, cnt_q;
  logic             retire, timeout;

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW, OP_WDT};
  endfunction

  function automatic ctl_t decode(input state_t st, input logic [5:0] op);
    ctl_t c;
    c = '0;
    case (st)
      FETCH: begin
        c.ir_en    = 1'b1;
        c.mem_read = 1'b1;
      end
      DECODE: begin
        c.r_1_en  = 1'b1;
        c.r_2_en  = 1'b1;
        c.illegal = !is_legal(op);
      end
      EXECUTE: begin
        c.alu_op    = (op == OP_R) ? 2'b10 : (op == OP_BEQ) ? 2'b01 : 2'b00;
        c.alu_src   = (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
        c.is_jump   = (op == OP_J);
        c.is_branch = (op == OP_BEQ);
        c.wdt_w_en  = (op == OP_WDT);
        c.retire    = (op == OP_J) || (op == OP_BEQ) || (op == OP_WDT);
      end
      MEM: begin
        c.mem_read        = (op == OP_LW);
        c.mem_write       = (op == OP_SW);
        c.retire_on_ready = (op == OP_SW);
      end
      WRITEBACK: begin
        c.w_en       = 1'b1;
        c.reg_dst    = (op == OP_R);
        c.mem_to_reg = (op == OP_LW);
        c.retire     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign retire  = ctl_q.retire | (ctl_q.retire_on_ready & bus.i_mem_ready);
  // A zero period disables the watchdog; a retire in the zero cycle wins.
  assign timeout = (period_q != '0) && (cnt_q == '0) && !retire;

  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    nxt_state = state_q;
    nxt_op    = op_q;
    case (state_q)
      FETCH: begin
        // ir_en low marks the idle cycle straight after reset release.
        if (ctl_q.ir_en && bus.i_mem_ready) begin
          nxt_state = DECODE;
          nxt_op    = bus.i_op_code;
        end
      end
      DECODE:  nxt_state = is_legal(op_q) ? EXECUTE : FETCH;
      EXECUTE: begin
        if ((op_q == OP_LW) || (op_q == OP_SW))        nxt_state = MEM;
        else if ((op_q == OP_R) || (op_q == OP_ADDI))  nxt_state = WRITEBACK;
        else                                           nxt_state = FETCH;
      end
      MEM: begin
        if (bus.i_mem_ready) nxt_state = (op_q == OP_SW) ? FETCH : WRITEBACK;
      end
      WRITEBACK: nxt_state = FETCH;
      default:   nxt_state = FETCH;
    endcase
    if (timeout) nxt_state = FETCH;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= FETCH;
      op_q     <= '0;
      ctl_q    <= '0;
      period_q <= WDT_DEFAULT;
      cnt_q    <= WDT_DEFAULT;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= nxt_state;
      op_q    <= nxt_op;
      ctl_q   <= decode(nxt_state, nxt_op);
      if (ctl_q.wdt_w_en) period_q <= bus.i_wdt_period;
      // The period write and its retire share a cycle, so the reload takes the new value.
      if (retire)                cnt_q <= ctl_q.wdt_w_en ? bus.i_wdt_period : period_q;
      else if (period_q != '0)   cnt_q <= (cnt_q == '0) ? period_q : cnt_q - 1'b1;
    end
  end

  assign bus.o_ir_en                = ctl_q.ir_en;
  assign bus.o_pc_en                = retire;
  assign bus.o_is_jump              = ctl_q.is_jump;
  assign bus.o_is_branch            = ctl_q.is_branch;
  assign bus.o_r_1_en               = ctl_q.r_1_en;
  assign bus.o_r_2_en               = ctl_q.r_2_en;
  assign bus.o_w_en                 = ctl_q.w_en;
  assign bus.o_reg_dst              = ctl_q.reg_dst;
  assign bus.o_alu_src              = ctl_q.alu_src;
  assign bus.o_mem_to_reg           = ctl_q.mem_to_reg;
  assign bus.o_mem_read             = ctl_q.mem_read;
  assign bus.o_mem_write            = ctl_q.mem_write;
  assign bus.o_alu_op_code          = ctl_q.alu_op;
  assign bus.o_wdt_wait_period_w_en = ctl_q.wdt_w_en;
  assign bus.o_state                = state_q;
  assign bus.o_retire               = retire;
  assign bus.o_illegal              = ctl_q.illegal;
  assign bus.o_wdt_timeout          = timeout;

endmodule

// File: doc/mips_control_multicycle_wdt.md
MIPS_CONTROL_MULTICYCLE_WDT -- requirements
Module: mips_control_multicycle_wdt

Interface
REQ-001 The block SHALL take parameter WDT_W, default 16: watchdog counter and period width.
REQ-002 The block SHALL take parameter WDT_DEFAULT, default {WDT_W{1'b1}}: period loaded at reset.
REQ-003 The block SHALL take parameter OP_WDT, default 6'h3F: opcode of the watchdog-period-write instruction.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset, with ports as listed:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-low
- i_op_code  in  6  instruction opcode from the instruction bus
- i_mem_ready  in  1  memory handshake: fetch, load or store completes this cycle
- i_wdt_period  in  WDT_W  new watchdog period, from the rt register read
- o_ir_en, o_pc_en  out  1  instruction-register load; PC update
- o_is_jump, o_is_branch  out  1  jump and branch select
- o_r_1_en, o_r_2_en, o_w_en  out  1  register-file read and write enables
- o_reg_dst, o_alu_src, o_mem_to_reg  out  1  datapath mux selects
- o_mem_read, o_mem_write  out  1  data-memory strobes
- o_alu_op_code  out  2  00 add, 01 sub, 10 funct-decoded
- o_wdt_wait_period_w_en  out  1  period-register write strobe
- o_state  out  3  current FSM state
- o_retire, o_illegal, o_wdt_timeout  out  1  single-cycle event pulses

Function
REQ-005 The FSM SHALL have states FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4; o_state SHALL equal the current state.
REQ-006 FETCH: o_ir_en=1 and o_mem_read=1; the FSM SHALL hold in FETCH until i_mem_ready=1.
REQ-007 On leaving FETCH, the block SHALL latch i_op_code into an internal opcode register, and all decoding SHALL use that register.
REQ-008 DECODE: o_r_1_en=1 and o_r_2_en=1. The FSM SHALL go to EXECUTE on a legal opcode: R 0x00, j 0x02, beq 0x04, addi 0x08, lw 0x23, sw 0x2B, or OP_WDT.
REQ-009 DECODE, other opcodes: the block SHALL pulse o_illegal and return to FETCH, with no retire and no PC update.
REQ-010 EXECUTE: the block SHALL drive o_alu_op_code 10 for R, 01 for beq, 00 otherwise, and o_alu_src=1 for addi, lw and sw.
- beq and j SHALL assert o_is_branch or o_is_jump respectively, then retire.
- OP_WDT SHALL assert o_wdt_wait_period_w_en, then retire.
- lw and sw SHALL go to MEM; R and addi SHALL go to WRITEBACK.
REQ-011 MEM: the block SHALL assert o_mem_read (lw) or o_mem_write (sw) and hold until i_mem_ready=1.
- sw SHALL then retire.
- lw SHALL then go to WRITEBACK.
REQ-012 WRITEBACK: o_w_en=1; o_reg_dst=1 for R only; o_mem_to_reg=1 for lw only. The instruction SHALL then retire.
REQ-013 Retire cycle: the last state cycle SHALL assert o_retire=1 and o_pc_en=1, and the next state SHALL be FETCH.
REQ-014 Cycle counts with zero wait states SHALL be: j/beq/OP_WDT 3, R/addi/sw 4, lw 5, illegal 2. Each low cycle of i_mem_ready SHALL add one cycle.
REQ-015 All control outputs SHALL be Moore outputs of the state and latched opcode. Any output not named for a state SHALL be 0.
REQ-016 Period register: on o_wdt_wait_period_w_en the block SHALL capture i_wdt_period.
- The new value SHALL take effect at the reload from that instruction's own retire.
- Period 0 SHALL disable the watchdog: the counter holds and o_wdt_timeout is never asserted.
REQ-017 Watchdog counter:
- decrements by 1 each cycle;
- reloads from the period register on o_retire;
- when it reaches 0 with no retire in that cycle, the block SHALL pulse o_wdt_timeout for one cycle, force the FSM to FETCH on the next edge, and reload the counter.
REQ-018 Simultaneous events: retire with counter 0 SHALL reload with no timeout. A timeout SHALL abort a pending MEM or WRITEBACK with no write strobe afterwards.

Reset
REQ-019 While i_reset=0, the block SHALL hold:
- the FSM in FETCH with the opcode register 0;
- the period register and counter at WDT_DEFAULT;
- every output 0 except o_state=0.
REQ-020 Reset asserted mid-instruction SHALL abort it asynchronously with no further strobes. The first fetch SHALL begin on the first rising edge after i_reset rises.

Verification
REQ-021 R-type 0x00 with i_mem_ready=1 -> states 0,1,2,4. o_alu_op_code=10 in EXECUTE; o_w_en=1 and o_reg_dst=1 in WRITEBACK; o_retire on cycle 4.
REQ-022 lw 0x23 with i_mem_ready low for 2 MEM cycles -> 7 cycles total. o_mem_read held through MEM; o_mem_to_reg=1 and o_w_en=1 in WRITEBACK.
REQ-023 Opcode 0x3E -> o_illegal pulse in cycle 2, return to FETCH, no o_retire and no o_pc_en.
REQ-024 OP_WDT with i_wdt_period=5, then i_mem_ready held 0 in FETCH -> o_wdt_timeout exactly 6 cycles after the retire cycle; FSM stays in FETCH; counter reloaded to 5.
REQ-025 OP_WDT with i_wdt_period=0, then i_mem_ready held 0 for 100000 cycles -> no o_wdt_timeout.
REQ-026 i_reset pulled low during the MEM state of sw -> o_mem_write drops immediately; o_state=0; counter=WDT_DEFAULT.
